fp_div_seq: RTL and testbench



---
 rtl/fp_div_seq.sv | 165 ++++++++++++++++
 tb/tb_fp_div_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per cycle.
// Optional round-to-nearest-even when FP_DIV_ROUND_NEAREST_EN is defined; truncates otherwise.
`timescale 1ns/1ps
module fp_div_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t            state_q, state_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       dvsr_q, dvsr_d;
    logic [ITER-1:0]   quo_q, quo_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              dz_q, dz_d;

    logic              rem_ge;
    logic [24:0]       rem_sub;
    logic [22:0]       norm_mant;
    logic signed [9:0] norm_exp, fin_exp;
    logic [23:0]       mant_rnd;
    logic              rnd_inc;
    logic [XLEN-1:0]   norm_result;
    logic              new_sign;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic              round_bit, sticky;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        dz_d     = dz_q;
        new_sign = a[31] ^ b[31];

        rem_ge  = rem_q >= {1'b0, dvsr_q};
        rem_sub = rem_ge ? rem_q - {1'b0, dvsr_q} : rem_q;

        // Quotient lies in [0.5, 2): top bit set means no normalisation shift is needed.
        if (quo_q[ITER-1]) begin
            norm_mant = quo_q[ITER-2:2];
            norm_exp  = exp_q;
        end else begin
            norm_mant = quo_q[ITER-3:1];
            norm_exp  = exp_q - 10'sd1;
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        round_bit = quo_q[ITER-1] ? quo_q[1] : quo_q[0];
        sticky    = (rem_q != 25'd0) || (quo_q[ITER-1] && quo_q[0]);
        rnd_inc   = round_bit && (sticky || norm_mant[0]);
`else
        rnd_inc   = 1'b0;
`endif
        mant_rnd = {1'b0, norm_mant} + {23'd0, rnd_inc};
        fin_exp  = mant_rnd[23] ? norm_exp + 10'sd1 : norm_exp;
        if (fin_exp >= 10'sd255)
            norm_result = {sign_q, 8'hFF, 23'd0};
        else if (fin_exp <= 10'sd0)
            norm_result = {sign_q, 31'd0};
        else
            norm_result = {sign_q, fin_exp[7:0], mant_rnd[22:0]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d = new_sign;
                    if (a[30:0] == 31'd0) begin
                        result_d = {new_sign, 31'd0};
                        dz_d     = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (b[30:0] == 31'd0) begin
                        result_d = {new_sign, 8'hFF, 23'd0};
                        dz_d     = 1'b1;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        rem_d   = {2'b01, a[22:0]};
                        dvsr_d  = {1'b1, b[22:0]};
                        exp_d   = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                        quo_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = {rem_sub[23:0], 1'b0};
                quo_d = {quo_q[ITER-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1))
                    state_d = NORM;
            end
            NORM: begin
                result_d = norm_result;
                dz_d     = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvsr_q   <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dz_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: scoreboard of expected quotients, latency and reset checks.
// Build with FP_DIV_ROUND_NEAREST_EN defined to exercise the rounding variant.
`timescale 1ns/1ps
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_busy = 0;
    logic done_prev = 1'b0;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, expv);
    endtask

    // Reference: long division by integer divide, independent of the shift-subtract loop.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [48:0] num, den, q, r;
        logic [22:0] mant;
        logic        rb, st;
        int          ex;
        logic        s;
        s = a[31] ^ b[31];
        e.dz = 1'b0;
        if (a[30:0] == 0) begin e.res = {s, 31'd0}; return e; end
        if (b[30:0] == 0) begin e.res = {s, 8'hFF, 23'd0}; e.dz = 1'b1; return e; end
        num = {25'd0, 1'b1, a[22:0]} << 25;
        den = {25'd0, 1'b1, b[22:0]};
        q = num / den;
        r = num % den;
        ex = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[25]) begin
            mant = q[24:2]; rb = q[1]; st = q[0] | (r != 0);
        end else begin
            mant = q[23:1]; rb = q[0]; st = (r != 0); ex = ex - 1;
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        if (rb && (st || mant[0])) begin
            if (mant == 23'h7FFFFF) begin mant = 0; ex = ex + 1; end
            else mant = mant + 1;
        end
`else
        if (rb && st) mant = mant;
`endif
        if (ex >= 255)    e.res = {s, 8'hFF, 23'd0};
        else if (ex <= 0) e.res = {s, 31'd0};
        else              e.res = {s, 8'(ex), mant};
        return e;
    endfunction

    // Scoreboard consumer: each done pulse pops one expectation.
    always @(negedge clk) begin
        if (done && done_prev) check("done_pulse_width", 32'd2, 32'd1);
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dz});
            end
        end
        done_prev = done;
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er, input logic edz);
        exp_t e;
        @(negedge clk);
        a_i = a; b_i = b; start = 1'b1;
        e.res = er; e.dz = edz;
        sb.push_back(e);
    endtask

    // Waits for the accepting edge, then counts edges until done is high (bounded).
    task automatic accept_and_wait(input string tag, input int exp_lat);
        int n;
        int bc;
        @(posedge clk);
        #1 start = 1'b0;
        a_i = $urandom; b_i = $urandom;
        n = 1; bc = 0;
        while (!done && n < 40) begin
            bc += int'(busy);
            @(posedge clk);
            n++;
            #1;
        end
        check(tag, 32'(n), 32'(exp_lat));
        last_busy = bc;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic edz, input int exp_lat);
        launch(a, b, er, edz);
        accept_and_wait(tag, exp_lat);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        exp_t        e;
        int          dcnt;

        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("lat_6div2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
        check("busy_cycles", 32'(last_busy), 32'd27);
`ifdef FP_DIV_ROUND_NEAREST_EN
        run_op("lat_1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);
`else
        run_op("lat_1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28);
`endif
        run_op("lat_neg", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 28);
        run_op("lat_ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28);
        run_op("lat_divzero", 32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        run_op("lat_zero_a", 32'h00000000, 32'h40E00000, 32'h00000000, 1'b0, 1);

        for (int i = 0; i < 5; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
            e = model(ra, rb);
            run_op("lat_random", ra, rb, e.res, e.dz, 28);
        end

        // Start held high with operands changing during DIV: exactly one completion.
        launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_i = $urandom; b_i = $urandom;
        end
        start = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1 dcnt += int'(done);
        end
        check("hold_start_dones", 32'(dcnt), 32'd1);

        // Back-to-back: start raised during DONE is only taken in the following IDLE cycle.
        launch(32'h3F800000, 32'h40400000, model(32'h3F800000, 32'h40400000).res, 1'b0);
        accept_and_wait("lat_b2b_first", 28);
        @(negedge clk);
        a_i = 32'hBFC00000; b_i = 32'h3F000000; start = 1'b1;
        e.res = 32'hC0400000; e.dz = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        accept_and_wait("lat_b2b_second", 28);
        @(posedge clk);

        // Asynchronous reset in the middle of DIV.
        launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        run_op("lat_after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
